uart_tx_fifo: RTL and testbench

//  Byte FIFO with a transmit sequencer between the memory-mapped UART TX data register and UART_TX.
//  The core queues bytes with back-to-back stores; no per-byte polling of the finish flag is needed.

---
 rtl/uart_tx_fifo_pkg.sv | 20 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: sequencer states, status bit
// positions and default geometry.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = 4;

    localparam int STATUS_EMPTY    = 8;
    localparam int STATUS_FULL     = 9;
    localparam int STATUS_BUSY     = 10;
    localparam int STATUS_OVERFLOW = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with wrap-bit pointers, sticky overflow and a flush that outranks
// both push and pop.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic              flush,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [7:0]      r_mem [DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                      (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign count    = r_wr_ptr - r_rd_ptr;
    assign overflow = r_overflow;
    assign rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];

    assign w_pop  = rd_en & ~empty;
    // A full queue still accepts a write when a slot frees on the same edge.
    assign w_push = wr_en & (~full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else if (wr_en) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queues bytes stored to the UART TX data register and launches them one at a
// time into UART_TX, waiting for each finish edge before the next launch.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        flush,
    input  logic        tx_finish,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] status,
    output logic [1:0]  dbg_state
);

    tx_state_t       r_state;
    tx_state_t       w_next_state;
    logic            r_fin_q;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic            w_fin_rise;
    logic            w_pop;
    logic [7:0]      w_rd_data;
    logic [ADDR_W:0] w_count;
    logic            w_unused_hi;

    assign w_unused_hi = ^wr_data[31:8];

    sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data[7:0]),
        .rd_en    (w_pop),
        .flush    (flush),
        .rd_data  (w_rd_data),
        .full     (full),
        .empty    (empty),
        .count    (w_count),
        .overflow (overflow)
    );

    assign w_fin_rise = tx_finish & ~r_fin_q;

    // A flush in IDLE suppresses the pop so the flushed byte is never launched.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty && !flush) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD:  w_next_state = ST_START;
            ST_START: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_fin_rise) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fin_q    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_fin_q    <= tx_finish;
            r_tx_start <= (w_next_state == ST_START);
            if (w_pop) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

    always_comb begin
        status                  = '0;
        status[STATUS_OVERFLOW] = overflow;
        status[STATUS_BUSY]     = busy;
        status[STATUS_FULL]     = full;
        status[STATUS_EMPTY]    = empty;
        status[ADDR_W:0]        = w_count;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: launch latency, ordering, full/overflow,
// flush, push-while-full-pop, pointer wrap, held finish and async reset.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        flush;
    logic        tx_finish;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        full;
    logic        empty;
    logic        busy;
    logic        overflow;
    logic [31:0] status;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .tx_finish (tx_finish),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow),
        .status    (status),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = {24'hABCDE0, b};
        step();
        wr_en   = 1'b0;
        wr_data = 32'h0;
    endtask

    task automatic fin_pulse();
        tx_finish = 1'b1;
        step();
        tx_finish = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    // Waits for a launch, checks latency and byte, then steps into WAIT.
    task automatic launch(input string tag, input int lat);
        int n;
        logic [7:0] e;
        wait_start(n);
        chk({tag, "_start"}, tx_start, 1'b1);
        if (lat >= 0) chk({tag, "_lat"}, n, lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_data"}, tx_data, e);
        step();
        chk({tag, "_pulse1"}, tx_start, 1'b0);
    endtask

    initial begin
        int n;
        int cnt;
        logic [7:0] b;

        rst = 1'b1; wr_en = 1'b0; wr_data = 32'h0; flush = 1'b0; tx_finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // 1: reset state and a single byte
        chk("rst_start", tx_start, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_status", status, 32'h0000_0100);
        chk("rst_state", dbg_state, 2'd0);
        exp_q.push_back(8'h41);
        write(8'h41);
        chk("t1_cnt1", status[4:0], 5'd1);
        step();
        chk("t1_busy", busy, 1'b1);
        chk("t1_empty", empty, 1'b1);
        chk("t1_data_load", tx_data, 8'h41);
        chk("t1_start_early", tx_start, 1'b0);
        launch("t1", 1);
        chk("t1_wait", dbg_state, 2'd3);
        fin_pulse();
        chk("t1_idle", busy, 1'b0);

        // 2: three back-to-back writes
        exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        write(8'h10); write(8'h11); write(8'h12);
        chk("t2_peak", status[4:0], 5'd2);
        launch("t2_b0", 0);
        fin_pulse(); launch("t2_b1", 2);
        fin_pulse(); launch("t2_b2", 2);
        fin_pulse();
        chk("t2_busy", busy, 1'b0);
        chk("t2_empty", empty, 1'b1);

        // 3: fill while held in WAIT, overflow, flush
        exp_q.push_back(8'hA0);
        write(8'hA0);
        launch("t3_a0", 2);
        for (int i = 0; i < 16; i++) write(8'hB0 + 8'(i));
        chk("t3_full", full, 1'b1);
        chk("t3_cnt16", status[4:0], 5'd16);
        chk("t3_noovf", overflow, 1'b0);
        write(8'hBF);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_status11", status[11], 1'b1);
        chk("t3_cnt_after", status[4:0], 5'd16);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t3_flush_cnt", status[4:0], 5'd0);
        chk("t3_flush_ovf", overflow, 1'b0);
        chk("t3_flush_empty", empty, 1'b1);
        chk("t3_inflight_busy", busy, 1'b1);
        chk("t3_inflight_data", tx_data, 8'hA0);
        fin_pulse();
        repeat (3) step();
        chk("t3_done_busy", busy, 1'b0);
        chk("t3_done_start", tx_start, 1'b0);

        // 4: full queue, pop and push on the same edge
        exp_q.push_back(8'hC0);
        write(8'hC0);
        launch("t4_c0", 2);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'hD0 + 8'(i));
            write(8'hD0 + 8'(i));
        end
        chk("t4_full", full, 1'b1);
        fin_pulse();
        chk("t4_idle_full", dbg_state, 2'd0);
        exp_q.push_back(8'hEE);
        write(8'hEE);
        chk("t4_cnt", status[4:0], 5'd16);
        chk("t4_still_full", full, 1'b1);
        chk("t4_ovf", overflow, 1'b0);
        chk("t4_busy", busy, 1'b1);
        launch("t4_d0", 1);
        for (int i = 1; i < 17; i++) begin
            fin_pulse();
            launch("t4_drain", 2);
        end
        fin_pulse();
        chk("t4_empty", empty, 1'b1);

        // 5: 40 bytes in three bursts across pointer wrap
        cnt = 0;
        for (int burst = 0; burst < 3; burst++) begin
            int len;
            len = (burst == 0) ? 14 : 13;
            for (int i = 0; i < len; i++) begin
                b = 8'((cnt * 37 + 5) & 255);
                cnt++;
                exp_q.push_back(b);
                write(b);
                if (i == 0) launch("t5_first", 2);
            end
            for (int i = 1; i < len; i++) begin
                fin_pulse();
                launch("t5_byte", 2);
            end
            fin_pulse();
        end
        chk("t5_count", cnt, 40);
        chk("t5_empty", empty, 1'b1);

        // 5b: finish held high for 5 cycles gives exactly one launch
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        write(8'h55); write(8'h66);
        launch("t5_55", 1);
        tx_finish = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx_start === 1'b1) begin
                n++;
                chk("t5_held_data", tx_data, 8'h66);
            end
        end
        tx_finish = 1'b0;
        repeat (2) begin
            step();
            if (tx_start === 1'b1) n++;
        end
        chk("t5_held_launches", n, 1);
        chk("t5_held_wait", dbg_state, 2'd3);
        void'(exp_q.pop_front());
        fin_pulse();
        chk("t5_held_idle", busy, 1'b0);

        // 6: async reset in WAIT and in START
        exp_q.push_back(8'h77);
        write(8'h77);
        launch("t6_77", 2);
        #2 rst = 1'b1;
        #1;
        chk("t6w_start", tx_start, 1'b0);
        chk("t6w_data", tx_data, 8'h00);
        chk("t6w_state", dbg_state, 2'd0);
        chk("t6w_status", status, 32'h0000_0100);
        #1 rst = 1'b0;
        step();
        write(8'h78);
        wait_start(n);
        chk("t6s_in_start", dbg_state, 2'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6s_start", tx_start, 1'b0);
        chk("t6s_data", tx_data, 8'h00);
        chk("t6s_state", dbg_state, 2'd0);
        chk("t6s_busy", busy, 1'b0);
        #1 rst = 1'b0;
        step();
        exp_q.delete();
        exp_q.push_back(8'h79);
        write(8'h79);
        launch("t6_restart", 2);
        fin_pulse();
        chk("t6_final_idle", busy, 1'b0);
        chk("t6_final_empty", empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
